// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V control path: opcodes, ALU
// class encodings, forwarding selects and the per-instruction control bundle.
package riscv_pkg;

  // Major opcodes recognised by the ID-stage decoder
  localparam logic [6:0] OP_ALU_R     = 7'b0110011;
  localparam logic [6:0] OP_ALU_I     = 7'b0010011;
  localparam logic [6:0] OP_BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] OP_JUMP      = 7'b1101111;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;

  // ALU class handed to the ALU controller
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_R_TYPE = 2'b10;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;

  // Control bundle produced by the decoder for one instruction
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_write;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding select.
// Inputs : EX/MEM and MEM/WB reg_write + rd, source registers of the EX instruction.
// Outputs: o_forward_a / o_forward_b (00 = regfile, 10 = EX/MEM, 01 = MEM/WB).
// Purely combinational.
module forwarding_unit
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_ex_mem_rd,
  input  logic                  i_mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_mem_wb_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1_ex,
  input  logic [REG_ADDR_W-1:0] i_rs2_ex,
  output logic [1:0]            o_forward_a,
  output logic [1:0]            o_forward_b
);

  logic w_ex_mem_valid;
  logic w_mem_wb_valid;

  // x0 is hardwired to zero, so a write to it is never a producer
  assign w_ex_mem_valid = i_ex_mem_reg_write && (i_ex_mem_rd != '0);
  assign w_mem_wb_valid = i_mem_wb_reg_write && (i_mem_wb_rd != '0);

  // Younger producer (EX/MEM) takes priority over MEM/WB
  always_comb begin
    o_forward_a = FWD_RF;
    o_forward_b = FWD_RF;

    if (w_ex_mem_valid && (i_ex_mem_rd == i_rs1_ex)) begin
      o_forward_a = FWD_EX_MEM;
    end else if (w_mem_wb_valid && (i_mem_wb_rd == i_rs1_ex)) begin
      o_forward_a = FWD_MEM_WB;
    end

    if (w_ex_mem_valid && (i_ex_mem_rd == i_rs2_ex)) begin
      o_forward_b = FWD_EX_MEM;
    end else if (w_mem_wb_valid && (i_mem_wb_rd == i_rs2_ex)) begin
      o_forward_b = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/control_pipeline.sv
// Pipelined control state for the 5-stage RISC-V datapath.
// Carries the decoder control bundle and register addresses through ID/EX,
// EX/MEM and MEM/WB; detects load-use hazards, applies branch/jump flushes
// and selects EX-stage forwarding.
// Inputs : clk, rst (sync, active-high), decoder bundle *_id, rs1/rs2/rd_id, flush_i.
// Outputs: ID/EX (*_ex), EX/MEM (*_mem), MEM/WB (*_wb) contents (registered);
//          forward_a/b, pc_write, if_id_write, if_id_flush (combinational).
module control_pipeline
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            alu_op_id,
  input  logic                  alu_src_id,
  input  logic                  branch_id,
  input  logic                  mem_read_id,
  input  logic                  mem_write_id,
  input  logic                  mem_2_reg_id,
  input  logic                  reg_write_id,
  input  logic                  jump_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  flush_i,
  output logic [1:0]            alu_op_ex,
  output logic                  alu_src_ex,
  output logic [REG_ADDR_W-1:0] rs1_ex,
  output logic [REG_ADDR_W-1:0] rs2_ex,
  output logic                  branch_mem,
  output logic                  jump_mem,
  output logic                  mem_read_mem,
  output logic                  mem_write_mem,
  output logic                  mem_2_reg_wb,
  output logic                  reg_write_wb,
  output logic [REG_ADDR_W-1:0] rd_wb,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush
);

  // ID/EX
  ctrl_t                 r_id_ex_ctrl;
  logic [REG_ADDR_W-1:0] r_id_ex_rs1;
  logic [REG_ADDR_W-1:0] r_id_ex_rs2;
  logic [REG_ADDR_W-1:0] r_id_ex_rd;

  // EX/MEM: only the fields still consumed downstream
  logic                  r_ex_mem_branch;
  logic                  r_ex_mem_jump;
  logic                  r_ex_mem_mem_read;
  logic                  r_ex_mem_mem_write;
  logic                  r_ex_mem_mem_2_reg;
  logic                  r_ex_mem_reg_write;
  logic [REG_ADDR_W-1:0] r_ex_mem_rd;

  // MEM/WB
  logic                  r_mem_wb_mem_2_reg;
  logic                  r_mem_wb_reg_write;
  logic [REG_ADDR_W-1:0] r_mem_wb_rd;

  ctrl_t w_id_ctrl;
  logic  w_load_use;
  logic  w_stall;

  // Pack the decoder bits into the bundle
  always_comb begin
    w_id_ctrl           = CTRL_BUBBLE;
    w_id_ctrl.alu_op    = alu_op_id;
    w_id_ctrl.alu_src   = alu_src_id;
    w_id_ctrl.branch    = branch_id;
    w_id_ctrl.mem_read  = mem_read_id;
    w_id_ctrl.mem_write = mem_write_id;
    w_id_ctrl.mem_2_reg = mem_2_reg_id;
    w_id_ctrl.reg_write = reg_write_id;
    w_id_ctrl.jump      = jump_id;
  end

  // Load-use hazard; a flush discards the dependent instruction anyway,
  // so it suppresses the stall and lets the front end redirect
  always_comb begin
    w_load_use  = r_id_ex_ctrl.mem_read && (r_id_ex_rd != '0) &&
                  ((r_id_ex_rd == rs1_id) || (r_id_ex_rd == rs2_id));
    w_stall     = w_load_use && !flush_i;
    pc_write    = !w_stall;
    if_id_write = !w_stall;
    if_id_flush = flush_i;
  end

  // Stage registers; reset overrides both stall and flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_ex_ctrl       <= CTRL_BUBBLE;
      r_id_ex_rs1        <= '0;
      r_id_ex_rs2        <= '0;
      r_id_ex_rd         <= '0;
      r_ex_mem_branch    <= 1'b0;
      r_ex_mem_jump      <= 1'b0;
      r_ex_mem_mem_read  <= 1'b0;
      r_ex_mem_mem_write <= 1'b0;
      r_ex_mem_mem_2_reg <= 1'b0;
      r_ex_mem_reg_write <= 1'b0;
      r_ex_mem_rd        <= '0;
      r_mem_wb_mem_2_reg <= 1'b0;
      r_mem_wb_reg_write <= 1'b0;
      r_mem_wb_rd        <= '0;
    end else begin
      if (flush_i || w_stall) begin
        r_id_ex_ctrl <= CTRL_BUBBLE;
        r_id_ex_rs1  <= '0;
        r_id_ex_rs2  <= '0;
        r_id_ex_rd   <= '0;
      end else begin
        r_id_ex_ctrl <= w_id_ctrl;
        r_id_ex_rs1  <= rs1_id;
        r_id_ex_rs2  <= rs2_id;
        r_id_ex_rd   <= rd_id;
      end

      // Instructions younger than the resolving branch/jump are squashed
      if (flush_i) begin
        r_ex_mem_branch    <= 1'b0;
        r_ex_mem_jump      <= 1'b0;
        r_ex_mem_mem_read  <= 1'b0;
        r_ex_mem_mem_write <= 1'b0;
        r_ex_mem_mem_2_reg <= 1'b0;
        r_ex_mem_reg_write <= 1'b0;
        r_ex_mem_rd        <= '0;
      end else begin
        r_ex_mem_branch    <= r_id_ex_ctrl.branch;
        r_ex_mem_jump      <= r_id_ex_ctrl.jump;
        r_ex_mem_mem_read  <= r_id_ex_ctrl.mem_read;
        r_ex_mem_mem_write <= r_id_ex_ctrl.mem_write;
        r_ex_mem_mem_2_reg <= r_id_ex_ctrl.mem_2_reg;
        r_ex_mem_reg_write <= r_id_ex_ctrl.reg_write;
        r_ex_mem_rd        <= r_id_ex_rd;
      end

      // The resolving branch/jump itself always retires
      r_mem_wb_mem_2_reg <= r_ex_mem_mem_2_reg;
      r_mem_wb_reg_write <= r_ex_mem_reg_write;
      r_mem_wb_rd        <= r_ex_mem_rd;
    end
  end

  forwarding_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_forwarding_unit (
    .i_ex_mem_reg_write (r_ex_mem_reg_write),
    .i_ex_mem_rd        (r_ex_mem_rd),
    .i_mem_wb_reg_write (r_mem_wb_reg_write),
    .i_mem_wb_rd        (r_mem_wb_rd),
    .i_rs1_ex           (r_id_ex_rs1),
    .i_rs2_ex           (r_id_ex_rs2),
    .o_forward_a        (forward_a),
    .o_forward_b        (forward_b)
  );

  assign alu_op_ex     = r_id_ex_ctrl.alu_op;
  assign alu_src_ex    = r_id_ex_ctrl.alu_src;
  assign rs1_ex        = r_id_ex_rs1;
  assign rs2_ex        = r_id_ex_rs2;
  assign branch_mem    = r_ex_mem_branch;
  assign jump_mem      = r_ex_mem_jump;
  assign mem_read_mem  = r_ex_mem_mem_read;
  assign mem_write_mem = r_ex_mem_mem_write;
  assign mem_2_reg_wb  = r_mem_wb_mem_2_reg;
  assign reg_write_wb  = r_mem_wb_reg_write;
  assign rd_wb         = r_mem_wb_rd;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: a list-of-instructions reference
// model predicts every output each cycle; a negedge monitor compares.
module tb_control_pipeline;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    alu_op_id;
  logic          alu_src_id, branch_id, mem_read_id, mem_write_id;
  logic          mem_2_reg_id, reg_write_id, jump_id;
  logic [AW-1:0] rs1_id, rs2_id, rd_id;
  logic          flush_i;
  logic [1:0]    alu_op_ex;
  logic          alu_src_ex;
  logic [AW-1:0] rs1_ex, rs2_ex;
  logic          branch_mem, jump_mem, mem_read_mem, mem_write_mem;
  logic          mem_2_reg_wb, reg_write_wb;
  logic [AW-1:0] rd_wb;
  logic [1:0]    forward_a, forward_b;
  logic          pc_write, if_id_write, if_id_flush;

  control_pipeline #(.REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_op_id(alu_op_id), .alu_src_id(alu_src_id), .branch_id(branch_id),
    .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
    .mem_2_reg_id(mem_2_reg_id), .reg_write_id(reg_write_id), .jump_id(jump_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .flush_i(flush_i),
    .alu_op_ex(alu_op_ex), .alu_src_ex(alu_src_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .branch_mem(branch_mem), .jump_mem(jump_mem), .mem_read_mem(mem_read_mem),
    .mem_write_mem(mem_write_mem), .mem_2_reg_wb(mem_2_reg_wb),
    .reg_write_wb(reg_write_wb), .rd_wb(rd_wb),
    .forward_a(forward_a), .forward_b(forward_b),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush)
  );

  always #5 clk = ~clk;

  // One instruction as seen by the model
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src, branch, mem_read, mem_write, mem_2_reg, reg_write, jump;
    logic [4:0] rs1, rs2, rd;
  } ins_t;

  typedef struct packed {
    logic [12:0] ex;
    logic [3:0]  mem;
    logic [6:0]  wb;
    logic [3:0]  fwd;
    logic [2:0]  fe;
  } exp_t;

  // in_flight[0] = in EX, [1] = in MEM, [2] = in WB
  ins_t in_flight [3];
  ins_t cur;
  logic cur_rst, cur_flush;
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  // Closest older instruction writing the register supplies the value
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    for (int k = 1; k <= 2; k++) begin
      if (in_flight[k].reg_write && in_flight[k].rd != 5'd0 && in_flight[k].rd == rs)
        return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic model_stall();
    return !cur_flush && in_flight[0].mem_read && in_flight[0].rd != 5'd0 &&
           (in_flight[0].rd == cur.rs1 || in_flight[0].rd == cur.rs2);
  endfunction

  task automatic set_inputs(input ins_t id, input logic r, input logic f);
    cur = id; cur_rst = r; cur_flush = f;
    rst = r; flush_i = f;
    alu_op_id = id.alu_op; alu_src_id = id.alu_src; branch_id = id.branch;
    mem_read_id = id.mem_read; mem_write_id = id.mem_write;
    mem_2_reg_id = id.mem_2_reg; reg_write_id = id.reg_write; jump_id = id.jump;
    rs1_id = id.rs1; rs2_id = id.rs2; rd_id = id.rd;
  endtask

  // Apply this cycle's inputs and queue the outputs the model predicts for it
  task automatic drive(input ins_t id, input logic r, input logic f);
    exp_t e;
    logic s;
    set_inputs(id, r, f);
    s     = model_stall();
    e.ex  = {in_flight[0].alu_op, in_flight[0].alu_src, in_flight[0].rs1, in_flight[0].rs2};
    e.mem = {in_flight[1].branch, in_flight[1].jump, in_flight[1].mem_read, in_flight[1].mem_write};
    e.wb  = {in_flight[2].mem_2_reg, in_flight[2].reg_write, in_flight[2].rd};
    e.fwd = {fwd_sel(in_flight[0].rs1), fwd_sel(in_flight[0].rs2)};
    e.fe  = {!s, !s, f};
    sb_q.push_back(e);
  endtask

  // Move instructions along at the clock edge
  task automatic tick();
    logic s;
    s = model_stall();
    if (cur_rst) begin
      for (int k = 0; k < 3; k++) in_flight[k] = '0;
    end else begin
      in_flight[2] = in_flight[1];
      in_flight[1] = cur_flush ? '0 : in_flight[0];
      in_flight[0] = (cur_flush || s) ? '0 : cur;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic rw, input logic ld);
    ins_t i;
    i = '0;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.reg_write = rw; i.mem_read = ld; i.mem_2_reg = ld;
    i.alu_src = ld;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i.alu_op    = 2'($urandom_range(0, 2));
    i.alu_src   = 1'($urandom_range(0, 1));
    i.branch    = ($urandom_range(0, 7) == 0);
    i.mem_read  = ($urandom_range(0, 3) == 0);
    i.mem_write = ($urandom_range(0, 5) == 0);
    i.mem_2_reg = 1'($urandom_range(0, 1));
    i.reg_write = 1'($urandom_range(0, 1));
    i.jump      = ($urandom_range(0, 7) == 0);
    i.rs1       = 5'($urandom_range(0, 7));
    i.rs2       = 5'($urandom_range(0, 7));
    i.rd        = 5'($urandom_range(0, 7));
    return i;
  endfunction

  // Monitor: compare DUT outputs against the oldest prediction
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("ex_stage",  16'({alu_op_ex, alu_src_ex, rs1_ex, rs2_ex}), 16'(e.ex));
      check("mem_stage", 16'({branch_mem, jump_mem, mem_read_mem, mem_write_mem}), 16'(e.mem));
      check("wb_stage",  16'({mem_2_reg_wb, reg_write_wb, rd_wb}), 16'(e.wb));
      check("forward",   16'({forward_a, forward_b}), 16'(e.fwd));
      check("front_end", 16'({pc_write, if_id_write, if_id_flush}), 16'(e.fe));
    end
  end

  initial begin : stim
    ins_t nop, a, held;
    logic r, f, hold;
    nop = '0;
    for (int k = 0; k < 3; k++) in_flight[k] = '0;

    // Reset held two cycles with ID asserting reg_write; first cycle is pre-reset
    a = mk(5'd7, 5'd1, 5'd2, 1'b1, 1'b0);
    set_inputs(a, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(a, 1'b1, 1'b0);
    @(negedge clk);
    check("rst_reg_write_wb", 16'(reg_write_wb), 16'd0);
    check("rst_pc_write", 16'(pc_write), 16'd1);
    tick();

    // Release: first sampled ID instruction reaches WB three cycles later
    drive(a, 1'b0, 1'b0);   tick();
    drive(nop, 1'b0, 1'b0); tick();
    drive(nop, 1'b0, 1'b0);
    @(negedge clk);
    check("wb_not_early", 16'(reg_write_wb), 16'd0);
    tick();
    drive(nop, 1'b0, 1'b0);
    @(negedge clk);
    check("wb_latency3", 16'({reg_write_wb, rd_wb}), 16'({1'b1, 5'd7}));
    tick();

    // Load-use on rs2
    drive(mk(5'd5, 5'd1, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0); tick();
    a = mk(5'd6, 5'd1, 5'd5, 1'b1, 1'b0);
    drive(a, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_stall", 16'({pc_write, if_id_write}), 16'd0);
    tick();
    drive(a, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_bubble", 16'({alu_op_ex, alu_src_ex, rs1_ex, rs2_ex}), 16'd0);
    check("lu_resume", 16'(pc_write), 16'd1);
    tick();
    drive(nop, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_fwd_b", 16'({rs2_ex, forward_b}), 16'({5'd5, 2'b01}));
    tick();

    // Forward priority, then MEM/WB-only producer
    for (int v = 0; v < 2; v++) begin
      drive(mk(5'd3, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0); tick();
      drive(mk(5'd3, 5'd0, 5'd0, (v == 0), 1'b0), 1'b0, 1'b0); tick();
      drive(mk(5'd4, 5'd3, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0); tick();
      drive(nop, 1'b0, 1'b0);
      @(negedge clk);
      check(v == 0 ? "fwd_prio_exmem" : "fwd_memwb", 16'(forward_a), v == 0 ? 16'd2 : 16'd1);
      tick();
    end

    // Register 0 never stalls nor forwards
    drive(mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0); tick();
    drive(mk(5'd8, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    @(negedge clk);
    check("x0_no_stall", 16'(pc_write), 16'd1);
    tick();
    drive(nop, 1'b0, 1'b0);
    @(negedge clk);
    check("x0_no_fwd", 16'({forward_a, forward_b}), 16'd0);
    tick();

    // Flush beats stall; jump in MEM writes its link register
    a = nop; a.jump = 1'b1; a.reg_write = 1'b1; a.rd = 5'd1;
    drive(a, 1'b0, 1'b0); tick();
    drive(mk(5'd5, 5'd2, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0); tick();
    drive(mk(5'd9, 5'd5, 5'd0, 1'b1, 1'b0), 1'b0, 1'b1);
    @(negedge clk);
    check("flush_over_stall", 16'({pc_write, if_id_write, if_id_flush}), 16'h7);
    tick();
    drive(nop, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_ex_bubble", 16'({alu_op_ex, alu_src_ex, rs1_ex, rs2_ex}), 16'd0);
    check("flush_mem_bubble", 16'({branch_mem, jump_mem, mem_read_mem, mem_write_mem}), 16'd0);
    check("flush_jump_wb", 16'({reg_write_wb, rd_wb}), 16'({1'b1, 5'd1}));
    tick();

    // Reset while a stall is pending
    drive(mk(5'd5, 5'd2, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0); tick();
    a = mk(5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
    drive(a, 1'b1, 1'b0); tick();
    drive(a, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_stall_cleared", 16'(pc_write), 16'd1);
    check("rst_stall_outputs", 16'({alu_op_ex, rs1_ex, mem_read_mem, reg_write_wb, rd_wb}), 16'd0);
    tick();

    // Randomized traffic; a stalled ID instruction is presented again
    hold = 1'b0;
    held = nop;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      f = !r && ($urandom_range(0, 9) == 0);
      a = hold ? held : rnd_ins();
      drive(a, r, f);
      hold = model_stall() && !r;
      held = a;
      tick();
    end

    drive(nop, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
# control_pipeline

Sequential consumer of the per-instruction control bundle produced by the ID-stage decoder. Carries that bundle, plus destination/source register addresses, through the ID/EX, EX/MEM and MEM/WB pipeline registers. Also performs load-use hazard detection (stall and bubble), branch/jump flush, and EX-stage forwarding selection for the 5-stage RISC-V datapath. It sits between the decoder and the datapath, and is the single owner of all pipelined control state.

## Interface
- `REG_ADDR_W`, default 5: register address width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_op_id` in 2: decoder ALU class. 00 = add, 01 = sub, 10 = R-type.
- `alu_src_id`, `branch_id`, `mem_read_id`, `mem_write_id`, `mem_2_reg_id`, `reg_write_id`, `jump_id` in 1 each: decoder control bits for the instruction in ID.
- `rs1_id`, `rs2_id`, `rd_id` in REG_ADDR_W: register fields of the instruction in ID.
- `flush_i` in 1: branch taken or jump resolved for the instruction currently in MEM.
- `alu_op_ex` out 2, `alu_src_ex` out 1, `rs1_ex`/`rs2_ex` out REG_ADDR_W: ID/EX contents.
- `branch_mem`, `jump_mem`, `mem_read_mem`, `mem_write_mem` out 1: EX/MEM contents.
- `mem_2_reg_wb`, `reg_write_wb` out 1, `rd_wb` out REG_ADDR_W: MEM/WB contents.
- `forward_a`, `forward_b` out 2: ALU operand select. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- `pc_write` out 1, `if_id_write` out 1, `if_id_flush` out 1: front-end pipeline control.

## Operation
- Bubble: all control bits 0, `alu_op` = 00, rd/rs = 0.
- Stage advance each cycle: ID→ID/EX, ID/EX→EX/MEM, EX/MEM→MEM/WB. Internal copies of rd, reg_write and mem_read are kept per stage.
- Load-use stall (`stall`) is asserted when all of the following hold:
  - ID/EX mem_read = 1,
  - ID/EX rd ≠ 0,
  - ID/EX rd equals `rs1_id` or `rs2_id`.
- Effect of stall: `pc_write` = 0 and `if_id_write` = 0, ID/EX loads a bubble, and EX/MEM and MEM/WB advance normally.
- Effect of flush (`flush_i` = 1):
  - ID/EX and EX/MEM load bubbles.
  - MEM/WB advances normally; the branch/jump itself completes.
  - `if_id_flush` = 1.
- Flush has priority over stall. While `flush_i` = 1, `stall` is forced to 0, so `pc_write` = `if_id_write` = 1.
- Forwarding for `forward_a` (same rule for `forward_b` using `rs2_ex`):
  - 10 if EX/MEM reg_write = 1, EX/MEM rd ≠ 0, and EX/MEM rd = `rs1_ex`.
  - Otherwise 01 if MEM/WB reg_write = 1, `rd_wb` ≠ 0, and `rd_wb` = `rs1_ex`.
  - Otherwise 00.
- Register 0 never triggers a stall or a forward.

## Timing
- Reset: on any edge with `rst` = 1, every pipeline register loads a bubble, overriding stall and flush.
  - All registered outputs read 0 on the following cycle.
  - `forward_*` = 00, `pc_write` = `if_id_write` = 1, `if_id_flush` = 0.
- Latency from ID inputs:
  - EX outputs: 1 cycle.
  - MEM outputs: 2 cycles.
  - WB outputs: 3 cycles.
- `stall`, `pc_write`, `if_id_write`, `if_id_flush` and `forward_*` are combinational. Sources are the current stage registers, the ID inputs and `flush_i`; there are no combinational paths from `rst`.
- A stall lasts exactly 1 cycle per load-use pair. After the bubble enters ID/EX, the held instruction re-evaluates against a non-load EX stage.
- `flush_i` is sampled at the edge and is a single-cycle pulse. If it is held for 2 cycles, both cycles flush independently.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants (ALU_R 0110011, ALU_I 0010011, BRANCH_EQ 1100011, JUMP 1101111, LOAD 0000011, STORE 0100011),
  - ALU_OP encodings (ADD 00, SUB 01, R_TYPE 10),
  - the forward-select encodings,
  - a packed control-bundle typedef and its BUBBLE constant.
- One sub-module, `forwarding_unit`: purely combinational, computes `forward_a`/`forward_b` from the EX/MEM and MEM/WB rd/reg_write and `rs1_ex`/`rs2_ex`.
- Stage registers and the hazard logic stay in `control_pipeline`.

## Test plan
- Reset, then release:
  - With `rst` held for 2 cycles and ID driving reg_write = 1, all outputs read 0 during reset.
  - After release, `reg_write_wb` = 1 exactly 3 cycles after the first sampled ID cycle.
- Load-use:
  - Stimulus: ID/EX holds a load with rd = 5, and ID has `rs2_id` = 5.
  - Required: `pc_write` = `if_id_write` = 0 for 1 cycle; the next cycle's ID/EX outputs are a bubble; the following cycle shows the held instruction in EX with `forward_b` = 01.
- Forward priority:
  - Stimulus: EX/MEM rd = 3 and MEM/WB rd = 3, both with reg_write = 1, and `rs1_ex` = 3.
  - Required: `forward_a` = 10.
  - With EX/MEM reg_write = 0 instead, `forward_a` = 01.
- Register 0:
  - Stimulus: a load with rd = 0 against `rs1_id` = 0, and an EX/MEM write to rd = 0 with `rs1_ex` = 0.
  - Required: no stall, and `forward_a` = 00.
- Flush beats stall:
  - Stimulus: `flush_i` = 1 in the same cycle a load-use condition exists.
  - Required: `pc_write` = 1, `if_id_flush` = 1, EX and MEM outputs are bubbles on the next cycle, and the branch's WB signals still appear.
- Reset during stall:
  - Stimulus: assert `rst` while stall = 1.
  - Required: the next cycle has all pipeline outputs at 0, and stall = 0.
